// File: rtl/crc_serial_accum.sv
`default_nettype none
// ============================================================================
//  Module   : crc_serial_accum  (plus its two-input XOR cell)
//  Purpose  : Bit-serial CRC accumulator. Takes one data bit per accepted
//             beat, MSB-first, and presents the frame CRC and the saturating
//             frame bit count once the bit flagged as last has been taken.
//             Every feedback and tap XOR is a discrete XOR cell instance.
//             The result is held until the consumer takes it.
//
//  Parameters
//    WIDTH   CRC register width (2..32)
//    POLY    generator polynomial, implicit x^WIDTH term omitted
//    INIT    register value at reset and at the start of every frame
//    CNT_W   width of the frame bit counter (saturates, never wraps)
//    XOROUT  final XOR mask, only used when CRC_SERIAL_XOROUT_EN is defined
//
//  Configuration macro
//    CRC_SERIAL_XOROUT_EN : when defined, out_crc = crc ^ XOROUT on entry to
//                           the result state. The mask is built from XOR
//                           cells. The running crc register is unaffected.
//                           When undefined, out_crc is the raw crc.
//
//  Ports
//    clk        in   1      rising-edge clock
//    rst        in   1      synchronous reset, active-high
//    in_valid   in   1      in_bit / in_last valid
//    in_ready   out  1      accumulator accepts a bit this cycle
//    in_bit     in   1      data bit, MSB-first
//    in_last    in   1      marks the final bit of a frame
//    out_valid  out  1      out_crc / out_nbits valid
//    out_ready  in   1      consumer accepts the result
//    out_crc    out  WIDTH  frame CRC
//    out_nbits  out  CNT_W  number of bits in the frame, saturating
//
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Two-input XOR cell. Kept as its own module so that every XOR in the
//  accumulator is a distinct, identifiable cell instance.
// ----------------------------------------------------------------------------
module crc_serial_accum_xor2 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);

    assign o_y = i_a ^ i_b;

endmodule

// ----------------------------------------------------------------------------
//  Accumulator top level
// ----------------------------------------------------------------------------
module crc_serial_accum #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] POLY   = 8'h07,
    parameter logic [WIDTH-1:0] INIT   = 8'h00,
    parameter int               CNT_W  = 16,
    parameter logic [WIDTH-1:0] XOROUT = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_crc,
    output logic [CNT_W-1:0] out_nbits
);

    // ------------------------------------------------------------------------
    //  State encoding: one-hot over two bits, so the two all-zero / all-one
    //  codes are detectably illegal and steer back to ST_ACCUM.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Datapath registers
    logic [WIDTH-1:0] r_crc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out_crc;
    logic [CNT_W-1:0] r_out_nbits;

    // Handshake / control decode
    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_accept_last;
    logic w_restart;

    // CRC update network
    logic             w_fb;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_crc_upd;
    logic [WIDTH-1:0] w_out_crc_d;

    // Counter update
    logic [CNT_W-1:0] w_cnt_upd;

    // ------------------------------------------------------------------------
    //  FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    //  FSM: next state and handshake outputs
    //  w_restart re-arms the frame registers both when the result is taken
    //  and when an illegal state is seen, so a corrupted state never leaves
    //  a partially accumulated CRC behind for the next frame.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_restart    = 1'b0;

        case (r_state)
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_ACCUM;
                    w_restart    = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
                w_restart    = 1'b1;
            end
        endcase
    end

    // in_ready is only high in ST_ACCUM, so a bit is never accepted in the
    // same cycle a result is released: the next frame starts one cycle later.
    assign w_accept      = in_valid & w_in_ready;
    assign w_accept_last = w_accept & in_last;

    // ------------------------------------------------------------------------
    //  CRC update network (Galois form, MSB-first)
    //    fb         = crc[MSB] ^ in_bit
    //    crc_upd[i] = shift[i] ^ (fb & POLY[i])
    //  Taps where POLY[i] = 0 reduce to a plain wire; the others are XOR
    //  cells fed by fb directly, since fb & 1 = fb.
    // ------------------------------------------------------------------------
    crc_serial_accum_xor2 u_xor_fb (
        .i_a (r_crc[WIDTH-1]),
        .i_b (in_bit),
        .o_y (w_fb)
    );

    assign w_shift = {r_crc[WIDTH-2:0], 1'b0};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
            if (POLY[gi]) begin : g_xor
                crc_serial_accum_xor2 u_xor_tap (
                    .i_a (w_shift[gi]),
                    .i_b (w_fb),
                    .o_y (w_crc_upd[gi])
                );
            end else begin : g_wire
                assign w_crc_upd[gi] = w_shift[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    //  Output mask. It is applied only to the captured result. The running
    //  crc register always carries the raw value.
    // ------------------------------------------------------------------------
`ifdef CRC_SERIAL_XOROUT_EN
    generate
        for (genvar gm = 0; gm < WIDTH; gm++) begin : g_xorout
            crc_serial_accum_xor2 u_xor_mask (
                .i_a (w_crc_upd[gm]),
                .i_b (XOROUT[gm]),
                .o_y (w_out_crc_d[gm])
            );
        end
    endgenerate
`else
    // XOROUT has no function in this build; it is folded into a deliberately
    // unused wire so the parameter stays part of the interface.
    logic w_unused_xorout;
    assign w_unused_xorout = ^XOROUT;
    assign w_out_crc_d     = w_crc_upd;
`endif

    // ------------------------------------------------------------------------
    //  Saturating bit counter: sticks at all-ones rather than wrapping, so
    //  very long frames report the maximum rather than a small bogus count.
    // ------------------------------------------------------------------------
    assign w_cnt_upd = (&r_cnt) ? r_cnt : (r_cnt + 1'b1);

    // ------------------------------------------------------------------------
    //  Frame accumulator registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= INIT;
            r_cnt <= '0;
        end else if (w_restart) begin
            r_crc <= INIT;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_crc <= w_crc_upd;
            r_cnt <= w_cnt_upd;
        end
    end

    // ------------------------------------------------------------------------
    //  Result registers: captured on the cycle the last bit is accepted and
    //  left untouched afterwards. They still show the previous result while
    //  the next frame accumulates.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_crc   <= '0;
            r_out_nbits <= '0;
        end else if (w_accept_last) begin
            r_out_crc   <= w_out_crc_d;
            r_out_nbits <= w_cnt_upd;
        end
    end

    // ------------------------------------------------------------------------
    //  Port drive
    // ------------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_crc   = r_out_crc;
    assign out_nbits = r_out_nbits;

endmodule

`default_nettype wire
